// File: rtl/ap_ctrl_initiator.sv
// ap_ctrl_chain initiator: issues ap_start/ap_continue for a commanded number of
// transactions, keeps a timestamp FIFO of accepted starts, and reports per-transaction latency.
module ap_ctrl_initiator #(
   parameter int CNT_W           = 32,
   parameter int TS_W            = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [7:0]       cmd_cont_delay,
   input  logic             abort,
   output logic             dut_ap_start,
   output logic             dut_ap_continue,
   input  logic             dut_ap_ready,
   input  logic             dut_ap_done,
   input  logic             dut_ap_idle,
   output logic             rec_valid,
   output logic [CNT_W-1:0] rec_index,
   output logic [TS_W-1:0]  rec_latency,
   output logic             busy,
   output logic             done_pulse,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] completed_cnt,
   output logic [TS_W-1:0]  max_latency,
   output logic             err_protocol
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_e;

   state_e           state_q, state_d;
   logic [TS_W-1:0]  cyc_q;
   logic             start_q, start_d, cont_q, cont_d;
   logic [7:0]       wait_q, wait_d, wait_inc;
   logic [7:0]       delay_q, delay_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [CNT_W-1:0] issued_q, issued_d, completed_q, completed_d;
   logic [TS_W-1:0]  max_q, max_d;
   logic             rec_valid_q, rec_valid_d;
   logic [CNT_W-1:0] rec_index_q, rec_index_d;
   logic [TS_W-1:0]  rec_lat_q, rec_lat_d;
   logic             err_q, err_d;
   logic             abort_q, abort_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic [TS_W-1:0]  ts_mem [MAX_OUTSTANDING];

   logic             cmd_acc, acc, cmpl, pop, spur, active_d, raise_d;
   logic [TS_W-1:0]  lat;
   logic             unused_idle;

   // Status only: the DUT's idle flag never steers control.
   assign unused_idle = dut_ap_idle;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign cmd_acc = (state_q == S_IDLE) && cmd_valid;
   assign acc     = start_q && dut_ap_ready;
   assign cmpl    = dut_ap_done && cont_q;
   assign pop     = cmpl && (occ_q != '0);
   assign spur    = cmpl && (occ_q == '0);
   assign lat     = cyc_q - ts_mem[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      target_d    = cmd_acc ? cmd_count : target_q;
      delay_d     = cmd_acc ? cmd_cont_delay : delay_q;
      abort_d     = abort_q;
      issued_d    = cmd_acc ? '0 : issued_q + CNT_W'(acc);
      completed_d = cmd_acc ? '0 : completed_q + CNT_W'(pop);
      max_d       = max_q;
      rec_valid_d = pop;
      rec_index_d = pop ? completed_q : rec_index_q;
      rec_lat_d   = pop ? lat : rec_lat_q;
      err_d       = err_q | spur;
      occ_d       = occ_q + OW'(acc) - OW'(pop);
      wr_ptr_d    = acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wait_inc    = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
      wait_d      = '0;
      cont_d      = 1'b0;

      if (cmd_acc) begin
         max_d   = '0;
         abort_d = 1'b0;
      end else begin
         if (pop && (lat > max_q)) max_d = lat;
         if ((state_q == S_ISSUE) && abort) abort_d = 1'b1;
      end

      case (state_q)
         S_IDLE:   if (cmd_acc) state_d = (cmd_count == '0) ? S_FINISH : S_ISSUE;
         // A pending start must be accepted before an abort can end issuing.
         S_ISSUE:  if ((issued_d == target_q) || ((abort || abort_q) && (!start_q || acc)))
                      state_d = S_DRAIN;
         S_DRAIN:  if (occ_q == '0) state_d = S_FINISH;
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      active_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
      // Evaluated on next-state values so an accepted start can stay high back-to-back.
      raise_d  = (state_d == S_ISSUE) && (occ_d < OW'(MAX_OUTSTANDING)) &&
                 (issued_d < target_d) && !(abort || abort_d);
      start_d  = (start_q && !acc) || raise_d;

      if (!active_d) begin
         cont_d = 1'b0;
      end else if (delay_d == 8'd0) begin
         cont_d = 1'b1;
      end else if (cmpl) begin
         cont_d = 1'b0;
      end else if (!dut_ap_done) begin
         cont_d = cont_q;
      end else if (cont_q) begin
         cont_d = 1'b1;
         wait_d = wait_q;
      end else begin
         wait_d = wait_inc;
         cont_d = (wait_inc >= delay_d);
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         start_q     <= 1'b0;
         cont_q      <= 1'b0;
         wait_q      <= '0;
         delay_q     <= '0;
         target_q    <= '0;
         issued_q    <= '0;
         completed_q <= '0;
         max_q       <= '0;
         rec_valid_q <= 1'b0;
         rec_index_q <= '0;
         rec_lat_q   <= '0;
         err_q       <= 1'b0;
         abort_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_q + TS_W'(1);
         start_q     <= start_d;
         cont_q      <= cont_d;
         wait_q      <= wait_d;
         delay_q     <= delay_d;
         target_q    <= target_d;
         issued_q    <= issued_d;
         completed_q <= completed_d;
         max_q       <= max_d;
         rec_valid_q <= rec_valid_d;
         rec_index_q <= rec_index_d;
         rec_lat_q   <= rec_lat_d;
         err_q       <= err_d;
         abort_q     <= abort_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (acc) ts_mem[wr_ptr_q] <= cyc_q;
   end

   assign cmd_ready       = (state_q == S_IDLE);
   assign busy            = (state_q != S_IDLE);
   assign done_pulse      = (state_q == S_FINISH);
   assign dut_ap_start    = start_q;
   assign dut_ap_continue = cont_q;
   assign rec_valid       = rec_valid_q;
   assign rec_index       = rec_index_q;
   assign rec_latency     = rec_lat_q;
   assign issued_cnt      = issued_q;
   assign completed_cnt   = completed_q;
   assign max_latency     = max_q;
   assign err_protocol    = err_q;

endmodule

// File: tb/tb_ap_ctrl_initiator.sv
// Bench for ap_ctrl_initiator: a behavioural DUT plus a transaction-level scoreboard
// (FIFO of acceptance cycles) predicts records, counters and protocol timing.
module tb_ap_ctrl_initiator;
   localparam int MAXO = 4;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        cmd_valid, cmd_ready, abort;
   logic [31:0] cmd_count;
   logic [7:0]  cmd_cont_delay;
   logic        dut_ap_start, dut_ap_continue, dut_ap_ready, dut_ap_done, dut_ap_idle;
   logic        rec_valid, busy, done_pulse, err_protocol;
   logic [31:0] rec_index, rec_latency, issued_cnt, completed_cnt, max_latency;

   ap_ctrl_initiator #(.CNT_W(32), .TS_W(32), .MAX_OUTSTANDING(MAXO)) u_dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
      .cmd_cont_delay(cmd_cont_delay), .abort(abort),
      .dut_ap_start(dut_ap_start), .dut_ap_continue(dut_ap_continue),
      .dut_ap_ready(dut_ap_ready), .dut_ap_done(dut_ap_done), .dut_ap_idle(dut_ap_idle),
      .rec_valid(rec_valid), .rec_index(rec_index), .rec_latency(rec_latency),
      .busy(busy), .done_pulse(done_pulse), .issued_cnt(issued_cnt),
      .completed_cnt(completed_cnt), .max_latency(max_latency), .err_protocol(err_protocol)
   );

   always #5 ap_clk = ~ap_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // scoreboard state
   int    q_acc[$];
   int    acc_cyc[$];
   int    comp_cyc[$];
   int    n = 0;
   bit    exp_err = 0;
   int    r_dp_at, r_nacc;

   task automatic reset_checks();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_start", dut_ap_start, 0);
      chk("rst_continue", dut_ap_continue, 0);
      chk("rst_rec_valid", rec_valid, 0);
      chk("rst_rec_index", rec_index, 0);
      chk("rst_rec_latency", rec_latency, 0);
      chk("rst_done_pulse", done_pulse, 0);
      chk("rst_issued", issued_cnt, 0);
      chk("rst_completed", completed_cnt, 0);
      chk("rst_max_latency", max_latency, 0);
      chk("rst_err", err_protocol, 0);
   endtask

   // rmode: 0 ready at once, 1 ready after start held rd cycles, 2 random ready
   task automatic run(input int count, input int dly, input bit pipe, input int lat,
                      input int rmode, input int rd, input int abort_at, input int spur_at,
                      input int reset_at, input int exp_lat);
      int  comp_n = 0, n_acc = 0, post_ab = 0, allowed = -1;
      int  dp_cnt = 0, dp_at = -1, waitc = 0, startc = 0, rec_idx_e = 0, rec_lat_e = 0;
      int  max_lat = 0, l, h;
      bit  rec_pend = 0, prev_start = 0, prev_acc = 0, rdy, done, ab, acc, cmpl;
      q_acc.delete(); acc_cyc.delete(); comp_cyc.delete();
      @(negedge ap_clk);
      chk("cmd_ready_before_run", cmd_ready, 1);
      cmd_valid = 1; cmd_count = count; cmd_cont_delay = dly[7:0];
      dut_ap_ready = 0; dut_ap_done = 0; abort = 0;
      @(negedge ap_clk);
      for (int i = 0; i < 2000; i++) begin
         if (rec_pend || rec_valid) begin
            chk("rec_valid", rec_valid, rec_pend);
            if (rec_pend) begin
               chk("rec_index", rec_index, rec_idx_e);
               chk("rec_latency", rec_latency, rec_lat_e);
               if (exp_lat >= 0) chk("rec_latency_fixed", rec_latency, exp_lat);
            end
         end
         rec_pend = 0;
         if (prev_start && !prev_acc) chk("start_held_until_accept", dut_ap_start, 1);
         if (done_pulse) begin dp_cnt++; if (dp_at < 0) dp_at = i; end
         if (i == reset_at) begin
            chk("pre_reset_busy", busy, 1);
            chk("pre_reset_outstanding", issued_cnt - completed_cnt, 2);
            ap_rst_n = 0;
            #1;
            reset_checks();
            q_acc.delete(); exp_err = 0;
            cmd_valid = 0; dut_ap_ready = 0; dut_ap_done = 0; abort = 0; dut_ap_idle = 1;
            @(negedge ap_clk);
            ap_rst_n = 1;
            return;
         end
         if (dp_at >= 0 && i == dp_at + 2) break;
         rdy = 0;
         if (pipe || q_acc.size() == 0) begin
            case (rmode)
               0: rdy = 1;
               1: rdy = (startc >= rd);
               default: rdy = ($urandom_range(1, 0) == 1);
            endcase
         end
         done = (q_acc.size() > 0) && (q_acc[0] + lat <= n);
         if (i == spur_at && q_acc.size() == 0) done = 1;
         ab   = (i == abort_at);
         acc  = dut_ap_start && rdy;
         cmpl = done && dut_ap_continue;
         if (ab) allowed = dut_ap_start ? 1 : 0;
         if (allowed >= 0 && acc) post_ab++;
         if (cmpl) begin
            if (q_acc.size() > 0) begin
               h = q_acc.pop_front();
               l = n - h;
               chk("continue_wait_cycles", waitc, dly);
               rec_pend = 1; rec_idx_e = comp_n; rec_lat_e = l;
               comp_n++;
               if (l > max_lat) max_lat = l;
               comp_cyc.push_back(n);
            end else begin
               exp_err = 1;
            end
         end
         if (done && !dut_ap_continue) waitc++; else waitc = 0;
         if (acc) begin
            q_acc.push_back(n); acc_cyc.push_back(n); n_acc++;
            chk("occupancy_le_max", q_acc.size() <= MAXO, 1);
         end
         if (dut_ap_start && !acc) startc++; else startc = 0;
         prev_start = dut_ap_start; prev_acc = acc;
         dut_ap_ready = rdy; dut_ap_done = done; abort = ab;
         dut_ap_idle = (q_acc.size() == 0);
         cmd_valid = (dp_at < 0);   // ignored while busy
         cmd_count = $urandom; cmd_cont_delay = 8'($urandom);
         n++;
         @(negedge ap_clk);
      end
      cmd_valid = 0; dut_ap_ready = 0; dut_ap_done = 0; abort = 0;
      chk("run_finished_in_budget", dp_at >= 0, 1);
      chk("done_pulse_count", dp_cnt, 1);
      chk("issued_cnt", issued_cnt, n_acc);
      chk("completed_cnt", completed_cnt, comp_n);
      chk("max_latency", max_latency, max_lat);
      chk("err_protocol", err_protocol, exp_err);
      chk("continue_low_idle", dut_ap_continue, 0);
      if (abort_at < 0) chk("issued_equals_cmd", n_acc, count);
      else if (allowed >= 0) chk("no_starts_after_abort", post_ab <= allowed, 1);
      r_dp_at = dp_at; r_nacc = n_acc;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ap_rst_n = 1; cmd_valid = 0; cmd_count = 0; cmd_cont_delay = 0; abort = 0;
      dut_ap_ready = 0; dut_ap_done = 0; dut_ap_idle = 1;
      #2 ap_rst_n = 0;
      #1 reset_checks();
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1;

      // 3 serial transactions, latency 5
      run(3, 0, 0, 5, 0, 0, -1, -1, -1, 5);
      chk("t1_max_latency", max_latency, 5);
      chk("t1_completed", completed_cnt, 3);

      // pipelined II=1, latency 10: 4 back-to-back, then stall for first completion
      run(8, 0, 1, 10, 0, 0, -1, -1, -1, 10);
      chk("t2_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
      chk("t2_stall_until_completion", acc_cyc[4] > comp_cyc[0], 1);

      // continue back-pressure of 2 cycles on a latency-5 DUT
      run(2, 2, 0, 5, 0, 0, -1, -1, -1, 7);
      chk("t3_max_latency", max_latency, 7);

      // ready 3 cycles late, abort pulsed while start is pending
      run(5, 0, 0, 5, 1, 3, 1, -1, -1, 5);
      chk("t4_single_transaction", r_nacc, 1);
      chk("t4_first_accept_cycle", acc_cyc[0] - (n - 12), 3);

      // zero-length run
      run(0, 0, 0, 5, 0, 0, -1, -1, -1, -1);
      chk("t5_finish_next_cycle", r_dp_at, 0);
      chk("t5_no_start", r_nacc, 0);

      // spurious ap_done with nothing outstanding
      run(1, 0, 0, 3, 1, 4, -1, 1, -1, 3);
      chk("t6_err_sticky", err_protocol, 1);

      for (int k = 0; k < 10; k++) begin
         run($urandom_range(12, 1), $urandom_range(3, 0), 1'($urandom_range(1, 0)),
             $urandom_range(12, 1), 2, 0,
             ($urandom_range(3, 0) == 0) ? $urandom_range(15, 0) : -1, -1, -1, -1);
      end

      // reset mid-drain, then a fresh single transaction
      run(2, 0, 1, 20, 0, 0, -1, -1, 6, -1);
      chk("t7_cmd_ready_after_reset", cmd_ready, 1);
      run(1, 0, 0, 4, 0, 0, -1, -1, -1, 4);
      chk("t7_completed_after_reset", completed_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
